ps2_capture_fifo: RTL and testbench

Parametrised capture buffer for PS/2 receive bytes. It sits directly behind PS2_Controller and accepts its one-cycle received_data_en strobe. It stores bytes in an inferred single-clock RAM. Stored bytes are presented oldest-first on a valid/ready read stream, for a CPU bus bridge or debug readout. This replaces the free-running write-only capture address counter: it adds read-back, occupancy, overflow reporting and a selectable full policy.

---
 rtl/ps2_capture_fifo.sv | 132 +++++++++++++
 tb/tb_ps2_capture_fifo.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_capture_fifo.sv
// Capture buffer behind the PS/2 receiver: RAM-backed FIFO with a show-ahead
// valid/ready read port, occupancy, sticky overflow and a selectable full policy.
module ps2_capture_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 10,
   parameter int RING_MODE  = 0
) (
   input  logic                  CLOCK_50,
   input  logic                  reset_n,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   input  logic                  capture_en,
   input  logic                  clear,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  empty,
   output logic                  full,
   output logic                  overflow
);

   localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] ONE_C   = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic                RING    = (RING_MODE != 0);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
   logic [DATA_WIDTH-1:0] ram_q;
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH:0]   ram_cnt;
   logic [ADDR_WIDTH:0]   ram_cnt_nxt;
   logic [ADDR_WIDTH:0]   count_nxt;
   logic                  pend;

   logic run;
   logic pop;
   logic wr_req;
   logic wr_drop;
   logic ovw;
   logic wr_ok;
   logic drop_out;
   logic drop_pend;
   logic drop_ram;
   logic out_free;
   logic load_out;
   logic pend_free;
   logic fetch;

   assign run     = reset_n && !clear;
   assign pop     = rd_valid && rd_ready;
   assign wr_req  = in_valid && capture_en;
   assign wr_drop = wr_req && full && !pop;
   assign ovw     = wr_drop && RING;
   assign wr_ok   = wr_req && (!full || pop || RING);

   // An overwrite discards the oldest entry wherever it currently sits:
   // output register, the pending RAM read, or (only if both are idle) the RAM.
   assign drop_out  = pop || (ovw && rd_valid);
   assign drop_pend = ovw && !rd_valid && pend;
   assign drop_ram  = ovw && !rd_valid && !pend;

   assign out_free  = !rd_valid || drop_out;
   assign load_out  = pend && out_free && !ovw;
   assign pend_free = !pend || load_out || drop_pend;
   assign fetch     = (ram_cnt != '0) && pend_free && !drop_ram;

   always_comb begin
      count_nxt   = count;
      ram_cnt_nxt = ram_cnt;
      if (wr_ok) begin
         count_nxt   = count_nxt + ONE_C;
         ram_cnt_nxt = ram_cnt_nxt + ONE_C;
      end
      if (pop || ovw) begin
         count_nxt = count_nxt - ONE_C;
      end
      if (fetch || drop_ram) begin
         ram_cnt_nxt = ram_cnt_nxt - ONE_C;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (run && wr_ok) begin
         mem[wr_ptr] <= in_data;
      end
      if (fetch) begin
         ram_q <= mem[rd_ptr];
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (!run) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         ram_cnt  <= '0;
         count    <= '0;
         empty    <= 1'b1;
         full     <= 1'b0;
         pend     <= 1'b0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
         end
         if (fetch || drop_ram) begin
            rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
         end
         ram_cnt <= ram_cnt_nxt;
         count   <= count_nxt;
         empty   <= (count_nxt == '0);
         full    <= (count_nxt == DEPTH_C);
         if (fetch) begin
            pend <= 1'b1;
         end else if (load_out || drop_pend) begin
            pend <= 1'b0;
         end
         if (load_out) begin
            rd_valid <= 1'b1;
            rd_data  <= ram_q;
         end else if (drop_out) begin
            rd_valid <= 1'b0;
         end
         if (wr_drop) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ps2_capture_fifo.sv
// Bench for ps2_capture_fifo: a stop-when-full and a ring instance share stimulus,
// each checked against its own queue model of the buffer.
module tb_ps2_capture_fifo;

   localparam int DW    = 8;
   localparam int AW    = 2;
   localparam int DEPTH = 4;

   logic          CLOCK_50 = 1'b0;
   logic          reset_n;
   logic          clear;
   logic          in_valid;
   logic          capture_en;
   logic          rd_ready;
   logic [DW-1:0] in_data;

   logic [DW-1:0] rd_data  [2];
   logic          rd_valid [2];
   logic [AW:0]   count    [2];
   logic          empty    [2];
   logic          full     [2];
   logic          overflow [2];

   always #10 CLOCK_50 = ~CLOCK_50;

   ps2_capture_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RING_MODE(0)) u_stop (
      .CLOCK_50(CLOCK_50), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
      .capture_en(capture_en), .clear(clear), .rd_data(rd_data[0]), .rd_valid(rd_valid[0]),
      .rd_ready(rd_ready), .count(count[0]), .empty(empty[0]), .full(full[0]),
      .overflow(overflow[0]));

   ps2_capture_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RING_MODE(1)) u_ring (
      .CLOCK_50(CLOCK_50), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
      .capture_en(capture_en), .clear(clear), .rd_data(rd_data[1]), .rd_valid(rd_valid[1]),
      .rd_ready(rd_ready), .count(count[1]), .empty(empty[1]), .full(full[1]),
      .overflow(overflow[1]));

   int            n_vec = 0;
   int            n_err = 0;
   logic [DW-1:0] mq   [2][$];
   logic [DW-1:0] got  [2][$];
   logic          mov  [2];
   int            zrun [2];
   int            maxc [2];

   typedef struct {
      logic          rst_n, clr, iv, ce;
      logic [DW-1:0] din;
      int            c0, c1;
      logic          v0, v1, o0, o1;
      logic [DW-1:0] d0, d1;
   } vec_t;

   vec_t tbl [14];

   task automatic chk(input string name, input int m, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, m, act, exp, $time);
      end
   endtask

   // One clock: snapshot the cycle's inputs, let the edge happen, advance the
   // model by the same rules, then compare everything observable.
   task automatic tick();
      logic          pop_s [2];
      logic [DW-1:0] d_s   [2];
      logic          wr_s, run_s, ovw_s;
      logic [DW-1:0] din_s;
      for (int m = 0; m < 2; m++) begin
         pop_s[m] = rd_valid[m] && rd_ready;
         d_s[m]   = rd_data[m];
      end
      wr_s  = in_valid && capture_en;
      run_s = reset_n && !clear;
      din_s = in_data;
      @(posedge CLOCK_50);
      #1;
      for (int m = 0; m < 2; m++) begin
         ovw_s = 1'b0;
         if (!run_s) begin
            mq[m].delete();
            mov[m]  = 1'b0;
            zrun[m] = 0;
         end else begin
            if (pop_s[m]) begin
               got[m].push_back(d_s[m]);
               if (mq[m].size() > 0) void'(mq[m].pop_front());
            end
            if (wr_s) begin
               if (mq[m].size() < DEPTH) begin
                  mq[m].push_back(din_s);
               end else begin
                  mov[m] = 1'b1;
                  if (m == 1) begin
                     void'(mq[m].pop_front());
                     mq[m].push_back(din_s);
                     ovw_s = 1'b1;
                  end
               end
            end
         end
         if (ovw_s) zrun[m] = 0;
         else if (mq[m].size() > 0 && !rd_valid[m]) zrun[m]++;
         else zrun[m] = 0;
         if (int'(count[m]) > maxc[m]) maxc[m] = int'(count[m]);

         chk("count", m, count[m], mq[m].size());
         chk("empty", m, empty[m], mq[m].size() == 0);
         chk("full", m, full[m], mq[m].size() == DEPTH);
         chk("overflow", m, overflow[m], mov[m]);
         chk("valid_gap", m, zrun[m] > 2, 0);
         if (rd_valid[m]) begin
            if (mq[m].size() == 0) chk("valid_when_empty", m, rd_valid[m], 0);
            else chk("rd_data", m, rd_data[m], mq[m][0]);
         end
      end
   endtask

   task automatic do_reset();
      reset_n    = 1'b0;
      clear      = 1'b0;
      in_valid   = 1'b0;
      capture_en = 1'b1;
      rd_ready   = 1'b0;
      in_data    = '0;
      tick();
      reset_n = 1'b1;
      for (int m = 0; m < 2; m++) begin
         got[m].delete();
         maxc[m] = 0;
      end
   endtask

   task automatic write1(input logic [DW-1:0] d);
      in_valid = 1'b1;
      in_data  = d;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int k = 0;
      rd_ready = 1'b1;
      in_valid = 1'b0;
      while ((count[0] != 0 || count[1] != 0) && k < 40) begin
         tick();
         k++;
      end
      chk("drain_timeout", 0, (count[0] != 0) || (count[1] != 0), 0);
      rd_ready = 1'b0;
   endtask

   function automatic vec_t mk(input logic rst_n, clr, iv, ce, input logic [DW-1:0] din,
                               input int c0, c1, input logic v0, v1, o0, o1,
                               input logic [DW-1:0] d0, d1);
      vec_t v;
      v.rst_n = rst_n; v.clr = clr; v.iv = iv; v.ce = ce; v.din = din;
      v.c0 = c0; v.c1 = c1; v.v0 = v0; v.v1 = v1; v.o0 = o0; v.o1 = o1;
      v.d0 = d0; v.d1 = d1;
      return v;
   endfunction

   initial begin
      logic [DW-1:0] eb [2][5];
      int            n;

      //               rst clr iv ce din    c0 c1 v0 v1 o0 o1 d0     d1
      tbl[0]  = mk(0, 0, 0, 1, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
      tbl[1]  = mk(1, 0, 1, 1, 8'h1C, 1, 1, 0, 0, 0, 0, 8'h00, 8'h00);
      tbl[2]  = mk(1, 0, 0, 1, 8'h00, 1, 1, 0, 0, 0, 0, 8'h00, 8'h00);
      tbl[3]  = mk(1, 0, 0, 1, 8'h00, 1, 1, 1, 1, 0, 0, 8'h1C, 8'h1C);
      tbl[4]  = mk(1, 0, 1, 1, 8'h32, 2, 2, 1, 1, 0, 0, 8'h1C, 8'h1C);
      tbl[5]  = mk(1, 0, 1, 1, 8'h21, 3, 3, 1, 1, 0, 0, 8'h1C, 8'h1C);
      tbl[6]  = mk(1, 0, 1, 1, 8'h23, 4, 4, 1, 1, 0, 0, 8'h1C, 8'h1C);
      tbl[7]  = mk(1, 0, 1, 1, 8'h24, 4, 4, 1, 0, 1, 1, 8'h1C, 8'h00);
      tbl[8]  = mk(1, 0, 0, 1, 8'h00, 4, 4, 1, 1, 1, 1, 8'h1C, 8'h32);
      tbl[9]  = mk(1, 1, 1, 1, 8'h77, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
      tbl[10] = mk(0, 0, 1, 0, 8'h77, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
      tbl[11] = mk(1, 0, 1, 1, 8'h1C, 1, 1, 0, 0, 0, 0, 8'h00, 8'h00);
      tbl[12] = mk(1, 0, 0, 1, 8'h00, 1, 1, 0, 0, 0, 0, 8'h00, 8'h00);
      tbl[13] = mk(1, 0, 0, 1, 8'h00, 1, 1, 1, 1, 0, 0, 8'h1C, 8'h1C);

      for (int m = 0; m < 2; m++) begin
         mov[m] = 1'b0; zrun[m] = 0; maxc[m] = 0;
      end
      reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0; capture_en = 1'b0;
      rd_ready = 1'b0; in_data = '0;
      repeat (2) @(posedge CLOCK_50);
      #1;

      for (int i = 0; i < 14; i++) begin
         reset_n    = tbl[i].rst_n;
         clear      = tbl[i].clr;
         in_valid   = tbl[i].iv;
         capture_en = tbl[i].ce;
         in_data    = tbl[i].din;
         rd_ready   = 1'b0;
         tick();
         chk("tbl_count", 0, count[0], tbl[i].c0);
         chk("tbl_count", 1, count[1], tbl[i].c1);
         chk("tbl_valid", 0, rd_valid[0], tbl[i].v0);
         chk("tbl_valid", 1, rd_valid[1], tbl[i].v1);
         chk("tbl_overflow", 0, overflow[0], tbl[i].o0);
         chk("tbl_overflow", 1, overflow[1], tbl[i].o1);
         if (tbl[i].v0) chk("tbl_data", 0, rd_data[0], tbl[i].d0);
         if (tbl[i].v1) chk("tbl_data", 1, rd_data[1], tbl[i].d1);
      end
      in_valid = 1'b0; clear = 1'b0; reset_n = 1'b1; capture_en = 1'b1;

      // Reset values, then a single entry held stable while not accepted.
      do_reset();
      for (int m = 0; m < 2; m++) chk("reset_rd_data", m, rd_data[m], 0);
      write1(8'h1C);
      repeat (2) tick();
      for (int c = 0; c < 10; c++) begin
         tick();
         for (int m = 0; m < 2; m++) begin
            chk("hold_valid", m, rd_valid[m], 1);
            chk("hold_data", m, rd_data[m], 8'h1C);
         end
      end

      // Fill past full: stop mode keeps the first four, ring keeps the last four.
      do_reset();
      write1(8'h1C); write1(8'h32); write1(8'h21); write1(8'h23);
      for (int m = 0; m < 2; m++) chk("full_after_4", m, full[m], 1);
      write1(8'h24);
      for (int m = 0; m < 2; m++) chk("ovf_after_5", m, overflow[m], 1);
      repeat (3) tick();
      drain();
      eb[0][0] = 8'h1C; eb[0][1] = 8'h32; eb[0][2] = 8'h21; eb[0][3] = 8'h23;
      eb[1][0] = 8'h32; eb[1][1] = 8'h21; eb[1][2] = 8'h23; eb[1][3] = 8'h24;
      for (int m = 0; m < 2; m++) begin
         chk("fill_pop_count", m, got[m].size(), 4);
         n = (got[m].size() < 4) ? got[m].size() : 4;
         for (int i = 0; i < n; i++) chk("fill_pop_order", m, got[m][i], eb[m][i]);
         chk("fill_empty", m, empty[m], 1);
      end

      // Full with a same-cycle write and pop: no overflow, new byte comes out last.
      do_reset();
      write1(8'h01); write1(8'h02); write1(8'h03); write1(8'h04);
      repeat (3) tick();
      in_valid = 1'b1; in_data = 8'h55; rd_ready = 1'b1;
      tick();
      in_valid = 1'b0; rd_ready = 1'b0;
      for (int m = 0; m < 2; m++) begin
         chk("full_rw_count", m, count[m], 4);
         chk("full_rw_ovf", m, overflow[m], 0);
      end
      drain();
      eb[0][0] = 8'h01; eb[0][1] = 8'h02; eb[0][2] = 8'h03; eb[0][3] = 8'h04; eb[0][4] = 8'h55;
      for (int m = 0; m < 2; m++) begin
         chk("full_rw_pops", m, got[m].size(), 5);
         n = (got[m].size() < 5) ? got[m].size() : 5;
         for (int i = 0; i < n; i++) chk("full_rw_order", m, got[m][i], eb[0][i]);
      end

      // Sparse stream across several pointer wraps.
      do_reset();
      rd_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         write1(DW'(i));
         repeat (2) tick();
      end
      drain();
      for (int m = 0; m < 2; m++) begin
         chk("stream_pops", m, got[m].size(), 10);
         n = (got[m].size() < 10) ? got[m].size() : 10;
         for (int i = 0; i < n; i++) chk("stream_order", m, got[m][i], i);
         chk("stream_max_count", m, maxc[m] > 1, 0);
      end

      // Randomised traffic in phases of light and heavy back-pressure.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         in_valid   = ($urandom_range(0, 2) == 0);
         in_data    = DW'($urandom);
         capture_en = ($urandom_range(0, 9) != 0);
         rd_ready   = ((c / 300) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
         clear      = ($urandom_range(0, 249) == 0);
         tick();
      end
      clear = 1'b0;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
